// File: rtl/router_input_port_if.sv
// router_input_port_if: link and switch-side signals of one router input port.
//   in_valid / in_flit   : inbound flit from the upstream link
//   credit_out           : one pulse per flit dequeued, returned upstream
//   out_valid / out_flit : flit offered to the router switch
//   out_port             : routed output port (0 local, 1 X-, 2 X+, 3 Y-, 4 Y+, 5 Z-, 6 Z+)
//   out_ready            : switch accepts out_flit this cycle
// slave = the input port itself, master = its environment (link + switch).
interface router_input_port_if #(
    parameter int unsigned FLIT_SIZE = 32
);
    logic                 in_valid;
    logic [1:FLIT_SIZE]   in_flit;
    logic                 credit_out;
    logic                 out_valid;
    logic [1:FLIT_SIZE]   out_flit;
    logic [2:0]           out_port;
    logic                 out_ready;

    modport slave (
        input  in_valid, in_flit, out_ready,
        output credit_out, out_valid, out_flit, out_port
    );

    modport master (
        output in_valid, in_flit, out_ready,
        input  credit_out, out_valid, out_flit, out_port
    );
endinterface

// File: rtl/router_input_port.sv
// router_input_port: per-input stage of the 3D-torus NoC router.
// Buffers inbound flits in a credit-controlled FIFO, routes each packet from its head flit
// (dimension order X, Y, Z, shortest way round the ring, tie to +) and offers the packet's
// flits to the switch with the output port held until the tail is dequeued.
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   io_bus     : link/switch bus (slave modport)
//   o_err_ovf  : sticky, flit arrived while FIFO full and nothing left
//   o_err_prot : sticky, non-head flit found at FIFO front while idle
// Flit bits [1:2] type (01 head, 00 body, 10 tail, 11 head+tail), [3:6] X, [7:10] Y, [11:14] Z.
module router_input_port #(
    parameter int unsigned FLIT_SIZE = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TORUS_K   = 10,
    parameter int unsigned MY_X      = 0,
    parameter int unsigned MY_Y      = 0,
    parameter int unsigned MY_Z      = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    router_input_port_if.slave    io_bus,
    output logic                  o_err_ovf,
    output logic                  o_err_prot
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {StIdle, StActive} state_e;

    logic [1:FLIT_SIZE] r_mem [DEPTH];
    logic [PtrW-1:0]    r_rd_ptr;
    logic [PtrW-1:0]    r_wr_ptr;
    logic [CntW-1:0]    r_count;
    state_e             r_state;
    logic [2:0]         r_port;
    logic               r_credit;
    logic               r_err_ovf;
    logic               r_err_prot;

    logic       w_empty;
    logic       w_full;
    logic [1:2] w_type;
    logic       w_valid;
    logic       w_deq;
    logic       w_prot_pop;
    logic       w_pop;
    logic       w_wr;
    logic [1:0] w_dx;
    logic [1:0] w_dy;
    logic [1:0] w_dz;
    logic [2:0] w_route;

    // Direction along one ring: 0 none, 1 minus, 2 plus. Destinations >= K wrap.
    function automatic logic [1:0] dim_dir(input logic [3:0] dest, input int unsigned my);
        int unsigned d;
        d = ({28'd0, dest} % TORUS_K + TORUS_K - my) % TORUS_K;
        if (d == 0) return 2'd0;
        else if (d <= TORUS_K / 2) return 2'd2;
        else return 2'd1;
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CntW'(DEPTH));
    assign w_type     = r_mem[r_rd_ptr][1:2];
    assign w_valid    = (r_state == StActive) && !w_empty;
    assign w_deq      = w_valid && io_bus.out_ready;
    // Idle with a non-head at the front: discard it so the next head can surface.
    assign w_prot_pop = (r_state == StIdle) && !w_empty && !w_type[2];
    assign w_pop      = w_deq || w_prot_pop;
    assign w_wr       = io_bus.in_valid && (!w_full || w_pop);

    always_comb begin
        w_dx = dim_dir(r_mem[r_rd_ptr][3:6], MY_X);
        w_dy = dim_dir(r_mem[r_rd_ptr][7:10], MY_Y);
        w_dz = dim_dir(r_mem[r_rd_ptr][11:14], MY_Z);
        if (w_dx != 2'd0)      w_route = {1'b0, w_dx};
        else if (w_dy != 2'd0) w_route = 3'(w_dy) + 3'd2;
        else if (w_dz != 2'd0) w_route = 3'(w_dz) + 3'd4;
        else                   w_route = 3'd0;
    end

    // Storage has no reset: contents are meaningless while the count says empty.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= io_bus.in_flit;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_port     <= 3'd0;
            r_credit   <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_prot <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (io_bus.in_valid && w_full && !w_pop) r_err_ovf <= 1'b1;
            if (w_prot_pop) r_err_prot <= 1'b1;
            case (r_state)
                StIdle: begin
                    if (!w_empty && w_type[2]) begin
                        r_port  <= w_route;
                        r_state <= StActive;
                    end
                end
                StActive: begin
                    if (w_deq && w_type[1]) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.out_valid  = w_valid;
    assign io_bus.out_flit   = r_mem[r_rd_ptr];
    assign io_bus.out_port   = r_port;
    assign io_bus.credit_out = r_credit;
    assign o_err_ovf         = r_err_ovf;
    assign o_err_prot        = r_err_prot;
endmodule

// File: tb/tb_router_input_port.sv
// Bench for router_input_port at MY=(3,4,5), K=10, DEPTH=4. Expected flits/ports are pushed
// to a scoreboard when driven and popped when the switch side dequeues.
module tb_router_input_port;
    localparam int unsigned FW = 32;

    typedef struct {
        logic [1:FW] flit;
        logic [2:0]  port;
    } exp_t;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
        logic [2:0] port;
    } route_t;

    logic clk;
    logic rst_n;
    logic err_ovf;
    logic err_prot;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_credit = 0;
    exp_t sb[$];
    exp_t mon_e;

    router_input_port_if #(.FLIT_SIZE(FW)) bus ();

    router_input_port #(
        .FLIT_SIZE(FW),
        .DEPTH    (4),
        .TORUS_K  (10),
        .MY_X     (3),
        .MY_Y     (4),
        .MY_Z     (5)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .io_bus    (bus),
        .o_err_ovf (err_ovf),
        .o_err_prot(err_prot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:FW] mk_flit(input logic [1:0] t, input logic [3:0] x,
                                            input logic [3:0] y, input logic [3:0] z,
                                            input logic [17:0] pay);
        logic [1:FW] f;
        f[1:2]   = t;
        f[3:6]   = x;
        f[7:10]  = y;
        f[11:14] = z;
        f[15:32] = pay;
        return f;
    endfunction

    // Called just after a rising edge; the flit is written at the next edge.
    task automatic drive_flit(input logic [1:FW] f);
        bus.in_valid = 1'b1;
        bus.in_flit  = f;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pkt1(input logic [1:FW] f, input logic [2:0] port);
        exp_t e;
        e.flit = f;
        e.port = port;
        sb.push_back(e);
        drive_flit(f);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Switch-side monitor and credit counter.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.credit_out) n_credit++;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_flit", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("flit", 64'(bus.out_flit), 64'(mon_e.flit));
                    check_eq("port", 64'(bus.out_port), 64'(mon_e.port));
                end
            end
        end
    end

    route_t routes[$];
    int     c0;

    initial begin
        // MY=(3,4,5)
        routes = '{
            '{x: 4'd9,  y: 4'd4,  z: 4'd5,  port: 3'd1},  // dx=6 -> X-
            '{x: 4'd8,  y: 4'd4,  z: 4'd5,  port: 3'd2},  // dx=5 tie -> X+
            '{x: 4'd13, y: 4'd4,  z: 4'd5,  port: 3'd0},  // 13 mod 10 = 3 -> local
            '{x: 4'd3,  y: 4'd1,  z: 4'd5,  port: 3'd3},  // dy=7 -> Y-
            '{x: 4'd3,  y: 4'd9,  z: 4'd5,  port: 3'd4},  // dy=5 -> Y+
            '{x: 4'd3,  y: 4'd4,  z: 4'd4,  port: 3'd5},  // dz=9 -> Z-
            '{x: 4'd3,  y: 4'd4,  z: 4'd10, port: 3'd6},  // z=0, dz=5 -> Z+
            '{x: 4'd2,  y: 4'd9,  z: 4'd9,  port: 3'd1},  // X decided first
            '{x: 4'd4,  y: 4'd0,  z: 4'd0,  port: 3'd2}   // dx=1 -> X+
        };

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_flit   = '0;
        bus.out_ready = 1'b1;

        // Reset held with random link activity.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_flit  = $urandom();
        end
        @(negedge clk);
        check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_port", 64'(bus.out_port), 64'd0);
        check_eq("rst_credit", 64'(bus.credit_out), 64'd0);
        check_eq("rst_errs", 64'({err_ovf, err_prot}), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("idle_valid", 64'(bus.out_valid), 64'd0);
        end
        check_eq("idle_credits", 64'(n_credit), 64'd0);
        @(posedge clk);
        #1;

        // Local single-flit packet with latency check.
        send_pkt1(mk_flit(2'b11, 4'd3, 4'd4, 4'd5, 18'h2a5a5), 3'd0);
        @(negedge clk);
        check_eq("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check_eq("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_drain(10);
        cycles(2);
        check_eq("local_credit", 64'(n_credit), 64'd1);
        check_eq("local_back_idle", 64'(bus.out_valid), 64'd0);

        // Route table.
        foreach (routes[i]) begin
            send_pkt1(mk_flit(2'b11, routes[i].x, routes[i].y, routes[i].z, 18'(i + 16)),
                      routes[i].port);
            wait_drain(12);
        end
        cycles(2);

        // Stalled 4-flit packet, then overflow.
        bus.out_ready = 1'b0;
        c0 = n_credit;
        send_pkt1(mk_flit(2'b01, 4'd9, 4'd4, 4'd5, 18'h00101), 3'd1);
        send_pkt1(mk_flit(2'b00, 4'd15, 4'd15, 4'd15, 18'h00202), 3'd1);
        send_pkt1(mk_flit(2'b00, 4'd0, 4'd0, 4'd0, 18'h00303), 3'd1);
        send_pkt1(mk_flit(2'b10, 4'd1, 4'd2, 4'd3, 18'h00404), 3'd1);
        cycles(2);
        check_eq("stall_no_ovf", 64'(err_ovf), 64'd0);
        check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
        check_eq("stall_port", 64'(bus.out_port), 64'd1);
        drive_flit(mk_flit(2'b00, 4'd7, 4'd7, 4'd7, 18'h3ffff));  // dropped
        @(negedge clk);
        check_eq("ovf_set", 64'(err_ovf), 64'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("burst_valid", 64'(bus.out_valid), 64'd1);
        end
        @(negedge clk);
        check_eq("burst_end_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        wait_drain(4);
        cycles(2);
        check_eq("burst_credits", 64'(n_credit - c0), 64'd4);

        // Lone body flit in idle.
        c0 = n_credit;
        drive_flit(mk_flit(2'b00, 4'd3, 4'd4, 4'd5, 18'h0beef));
        cycles(4);
        check_eq("prot_set", 64'(err_prot), 64'd1);
        check_eq("prot_credit", 64'(n_credit - c0), 64'd1);
        check_eq("ovf_sticky", 64'(err_ovf), 64'd1);

        // Reset mid-packet.
        bus.out_ready = 1'b0;
        send_pkt1(mk_flit(2'b01, 4'd3, 4'd4, 4'd10, 18'h11111), 3'd6);
        send_pkt1(mk_flit(2'b00, 4'd0, 4'd0, 4'd0, 18'h22222), 3'd6);
        @(negedge clk);
        check_eq("midpkt_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("async_rst_errs", 64'({err_ovf, err_prot}), 64'd0);
        sb.delete();
        cycles(2);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        c0            = n_credit;
        cycles(1);
        send_pkt1(mk_flit(2'b11, 4'd9, 4'd4, 4'd5, 18'h33333), 3'd1);
        wait_drain(12);
        cycles(3);
        check_eq("post_rst_no_prot", 64'(err_prot), 64'd0);
        check_eq("post_rst_credit", 64'(n_credit - c0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
